fir_seq_mac: RTL and testbench



---
 rtl/fir_pkg.sv | 7 +
 rtl/fir_delay_line.sv | 15 +
 rtl/fir_seq_mac.sv | 82 ++++++++
 tb/tb_fir_seq_mac.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type and width helper for the sequential FIR MAC.
package fir_pkg;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    function automatic int acc_width(int w, int taps);
        return 2 * w + $clog2(taps);
    endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: sample history shift register, x[0] (newest) in the low W bits.
module fir_delay_line #(
    parameter int W = 4,
    parameter int TAPS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic [W-1:0]      din,
    output logic [TAPS*W-1:0] taps
);
    always_ff @(posedge clk)
        if (!rst_n) taps <= '0;
        else if (shift_en) taps <= {taps[(TAPS-1)*W-1:0], din};
endmodule

// File: rtl/fir_seq_mac.sv
// fir_seq_mac: time-multiplexed unsigned FIR, one multiply-accumulate per tap per cycle.
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int W = 4,
    parameter int TAPS = 10,
    localparam int AW = $clog2(TAPS),
    localparam int ACCW = acc_width(W, TAPS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [W-1:0]    coef_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic            busy
);
    state_t             state, state_n;
    logic [W-1:0]       h [TAPS];
    logic [W-1:0]       x [TAPS];
    logic [TAPS*W-1:0]  taps;
    logic [AW-1:0]      idx;
    logic [ACCW-1:0]    acc, sum;
    logic [2*W-1:0]     prod;
    logic               accept, last;

    fir_delay_line #(.W(W), .TAPS(TAPS)) u_dl (
        .clk(clk), .rst_n(rst_n), .shift_en(accept), .din(in_data), .taps(taps)
    );

    for (genvar k = 0; k < TAPS; k++) begin : g_x
        assign x[k] = taps[k*W +: W];
    end

    always_comb begin
        in_ready = state == IDLE;
        busy = state != IDLE;
        accept = in_ready && in_valid;
        last = idx == AW'(TAPS - 1);
        prod = x[idx] * h[idx];
        sum = acc + ACCW'(prod);
        state_n = accept ? MAC
                : (state == MAC && last) ? OUT
                : (state == OUT && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    // Coefficients only change while idle so a running MAC sees a stable bank.
    always_ff @(posedge clk)
        if (!rst_n) for (int i = 0; i < TAPS; i++) h[i] <= '0;
        else if (coef_we && in_ready && int'(coef_addr) < TAPS) h[coef_addr] <= coef_data;

    always_ff @(posedge clk)
        if (!rst_n) begin
            acc <= '0;
            idx <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                acc <= '0;
                idx <= '0;
            end
            if (state == MAC) begin
                acc <= sum;
                if (!last) idx <= idx + 1'b1;
                if (last) begin
                    out_data <= sum;
                    out_valid <= 1'b1;
                end
            end
            if (state == OUT && out_ready) out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_fir_seq_mac.sv
// tb_fir_seq_mac: directed self-checking bench for the sequential FIR MAC.
module tb_fir_seq_mac;
    localparam int W = 4, TAPS = 10, AW = 4, ACCW = 12;

    logic            clk = 0, rst_n = 0, coef_we = 0, in_valid = 0, out_ready = 0;
    logic [AW-1:0]   coef_addr = '0;
    logic [W-1:0]    coef_data = '0, in_data = '0;
    logic            in_ready, out_valid, busy;
    logic [ACCW-1:0] out_data, held;
    int              checks = 0, errors = 0;

    fir_seq_mac #(.W(W), .TAPS(TAPS)) dut (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; coef_we = 0; out_ready = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    // mode 0: h[k]=value, mode 1: h[k]=k
    task automatic load_h(input int mode, input int value);
        for (int k = 0; k < TAPS; k++) begin
            coef_we = 1; coef_addr = AW'(k); coef_data = W'(mode == 1 ? k : value);
            @(posedge clk); #1;
        end
        coef_we = 0;
    endtask

    // Accept edge E0, result appears TAPS edges later (E_TAPS), then handshake.
    task automatic run_sample(input int xv, input int exp, input string tag);
        int n;
        in_data = W'(xv); in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, TAPS);
        check({tag, " data"}, out_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        do_reset();
        check("rst out_data", out_data, 0);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 1);
        check("rst busy", busy, 0);

        load_h(0, 1);
        for (int i = 1; i <= TAPS; i++) run_sample(15, 15 * i, $sformatf("ramp%0d", i));
        check("ramp idle in_ready", in_ready, 1);

        do_reset();
        load_h(1, 0);
        for (int i = 0; i < TAPS; i++) run_sample(i == 0 ? 1 : 0, i, $sformatf("imp%0d", i));

        do_reset();
        load_h(0, 15);
        for (int i = 1; i <= TAPS; i++) run_sample(15, 225 * i, $sformatf("max%0d", i));

        // Backpressure: result held while out_ready low, new sample waits.
        do_reset();
        load_h(0, 1);
        in_data = 5; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        in_data = 2;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", n, TAPS);
        held = out_data;
        check("bp data", held, 5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp valid%0d", i), out_valid, 1);
            check($sformatf("bp stable%0d", i), out_data, held);
            check($sformatf("bp in_ready%0d", i), in_ready, 0);
        end
        check("bp busy", busy, 1);
        out_ready = 1;
        @(posedge clk); #1;
        check("bp release valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);
        check("bp retain data", out_data, 5);
        @(posedge clk); #1;
        in_valid = 0;
        check("bp second accepted", busy, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp2 data", out_data, 7);
        @(posedge clk); #1;

        // Coefficient write during MAC is dropped.
        do_reset();
        load_h(0, 1);
        in_data = 4; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        coef_we = 1; coef_addr = 0; coef_data = 7;
        @(posedge clk); #1;
        coef_we = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("cw result", out_data, 4);
        @(posedge clk); #1;
        run_sample(1, 5, "cw probe");

        // Out-of-range coefficient address is ignored.
        coef_we = 1; coef_addr = 12; coef_data = 9;
        @(posedge clk); #1;
        coef_we = 0;
        run_sample(0, 5, "oob probe");

        // Reset sampled at E5 abandons the computation.
        in_data = 9; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("mid rst out_valid", out_valid, 0);
        check("mid rst in_ready", in_ready, 1);
        check("mid rst busy", busy, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("mid rst no pulse", n, 0);
        load_h(0, 1);
        run_sample(3, 3, "post rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
